// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: sequences weight load, settle, activation execute and drain
// for a row x col mac_tile array. It drives the west-edge per-row instructions
// with a one-cycle-per-row skew and owns the read ports of both SRAMs.
module mac_array_ctrl #(
    parameter int unsigned row     = 4,
    parameter int unsigned col     = 4,
    parameter int unsigned len_bw  = 8,
    parameter int unsigned addr_bw = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [len_bw-1:0]    len,
    output logic                 busy,
    output logic                 done,
    output logic [2*row-1:0]     inst_w,
    output logic                 w_rd_en,
    output logic [addr_bw-1:0]   w_rd_addr,
    output logic                 a_rd_en,
    output logic [addr_bw-1:0]   a_rd_addr
);

    localparam int unsigned drain_cyc = row + col + 1;
    localparam int unsigned drain_bw  = $clog2(drain_cyc + 1);
    localparam int unsigned cnt_bw    = (len_bw > drain_bw) ? len_bw : drain_bw;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]         state, state_nxt;
    logic [cnt_bw-1:0]  cnt, cnt_nxt;
    logic [len_bw-1:0]  len_q;
    logic [2*row-1:0]   inst_nxt;

    // Next-state and phase counter; the counter restarts at 0 on every state entry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + cnt_bw'(1);
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (cnt == cnt_bw'(col - 1)) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt == cnt_bw'(col - 1)) begin
                    state_nxt = (len_q == '0) ? S_DRAIN : S_EXEC;
                    cnt_nxt   = '0;
                end
            end
            S_EXEC: begin
                if (cnt == cnt_bw'(len_q - len_bw'(1))) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt == cnt_bw'(drain_cyc - 1)) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Instruction wavefront: row 0 takes the SRAM enables one cycle late, row r lags r more.
    always_comb begin
        inst_nxt      = inst_w << 2;
        inst_nxt[1:0] = {a_rd_en, w_rd_en};
    end

    // State, job length and registered outputs decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            len_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            inst_w    <= '0;
            w_rd_en   <= 1'b0;
            w_rd_addr <= '0;
            a_rd_en   <= 1'b0;
            a_rd_addr <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            if (state == S_IDLE && start) len_q <= len;
            busy    <= (state_nxt == S_LOAD) || (state_nxt == S_SETTLE) ||
                       (state_nxt == S_EXEC) || (state_nxt == S_DRAIN);
            done    <= (state_nxt == S_DONE);
            inst_w  <= inst_nxt;
            w_rd_en <= (state_nxt == S_LOAD);
            a_rd_en <= (state_nxt == S_EXEC);
            if (state_nxt == S_LOAD) w_rd_addr <= addr_bw'(cnt_nxt);
            if (state_nxt == S_EXEC) a_rd_addr <= addr_bw'(cnt_nxt);
        end
    end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: randomized and directed stimulus against a cycle-offset
// reference model of the controller's job timeline.
module tb_mac_array_ctrl;

    localparam int ROW = 4;
    localparam int COL = 4;
    localparam int LBW = 8;
    localparam int ABW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [LBW-1:0]  len = '0;
    logic            busy, done, w_rd_en, a_rd_en;
    logic [2*ROW-1:0] inst_w;
    logic [ABW-1:0]  w_rd_addr, a_rd_addr;

    mac_array_ctrl #(.row(ROW), .col(COL), .len_bw(LBW), .addr_bw(ABW)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .busy(busy), .done(done), .inst_w(inst_w),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr)
    );

    always #5 clk = ~clk;

    logic [27:0] obs;
    assign obs = {busy, done, inst_w, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr};

    int n_run  = 0;
    int n_fail = 0;

    // Reference model: cycles elapsed since the accepted start (-1 when idle).
    int          m_k   = -1;
    int          m_len = 0;
    logic [7:0]  m_wa  = '0;
    logic [7:0]  m_aa  = '0;
    logic [27:0] exp_v;

    function automatic int job_len_total(input int ln);
        return 3 * COL + ROW + ln + 2;
    endfunction

    function automatic logic [1:0] op_at(input int k, input int ln);
        if (k >= 1 && k <= COL) return 2'b01;
        if (k >= 2 * COL + 1 && k <= 2 * COL + ln) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_edge(input logic st, input logic rs, input int ln);
        int t;
        logic [7:0] ins;
        if (rs) begin
            m_k = -1; m_wa = '0; m_aa = '0;
        end else if (m_k < 0) begin
            if (st) begin m_k = 1; m_len = ln; end
        end else begin
            m_k++;
            if (m_k > job_len_total(m_len)) m_k = -1;
        end
        if (m_k >= 1 && m_k <= COL) m_wa = 8'(m_k - 1);
        if (m_k >= 2 * COL + 1 && m_k <= 2 * COL + m_len) m_aa = 8'(m_k - 2 * COL - 1);
        t = job_len_total(m_len);
        for (int r = 0; r < ROW; r++)
            ins[2*r +: 2] = (m_k < 0) ? 2'b00 : op_at(m_k - 1 - r, m_len);
        exp_v = {(m_k >= 1 && m_k <= t - 1), (m_k == t), ins,
                 (op_at(m_k, m_len) == 2'b01), m_wa,
                 (op_at(m_k, m_len) == 2'b10), m_aa};
    endtask

    // Drive one cycle's inputs, advance DUT and model, sample #1 after the edge.
    task automatic cyc(input logic st, input logic rs, input int ln);
        start = st; reset = rs; len = LBW'(ln);
        model_edge(st, rs, ln);
        @(posedge clk);
        #1;
        start = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 7; c++) begin
            cyc(1'b0, (c < 2), 0);
            n_run++;
            if (obs !== exp_v || obs !== 28'h0) begin
                n_fail++;
                $display("FAIL reset c%0d got=%h exp=%h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_nominal();
        int done_at = -1;
        cyc(1'b1, 1'b0, 3);
        for (int c = 1; c <= 22; c++) begin
            n_run++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL nominal c%0d got=%h exp=%h", c, obs, exp_v);
            end
            if (done === 1'b1 && done_at < 0) done_at = c;
            if (c == 2 || c == 5 || c == 10 || c == 15) begin
                n_run++;
                if (inst_w[1:0] !== ((c == 2 || c == 5) ? 2'b01 : (c == 10 ? 2'b10 : 2'b00)) ||
                    inst_w[7:6] !== ((c == 5) ? 2'b01 : (c == 15 ? 2'b10 : 2'b00))) begin
                    n_fail++;
                    $display("FAIL nominal_inst c%0d got=%b", c, inst_w);
                end
            end
            if (c < 22) cyc(1'b0, 1'b0, 0);
        end
        n_run++;
        if (done_at != 21) begin
            n_fail++;
            $display("FAIL nominal_done got=%0d exp=21", done_at);
        end
    endtask

    task automatic test_zero_len();
        int done_at = -1;
        logic saw_exec = 1'b0;
        cyc(1'b1, 1'b0, 0);
        for (int c = 1; c <= 19; c++) begin
            n_run++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL zero_len c%0d got=%h exp=%h", c, obs, exp_v);
            end
            if (done === 1'b1 && done_at < 0) done_at = c;
            for (int r = 0; r < ROW; r++) if (inst_w[2*r+1] === 1'b1) saw_exec = 1'b1;
            if (a_rd_en === 1'b1) saw_exec = 1'b1;
            if (c < 19) cyc(1'b0, 1'b0, 0);
        end
        n_run++;
        if (done_at != 18 || saw_exec) begin
            n_fail++;
            $display("FAIL zero_len_done got=%0d exec=%0b exp=18 exec=0", done_at, saw_exec);
        end
    endtask

    task automatic test_start_while_busy();
        int done_cnt = 0;
        cyc(1'b1, 1'b0, 3);
        for (int c = 1; c <= 26; c++) begin
            n_run++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL start_busy c%0d got=%h exp=%h", c, obs, exp_v);
            end
            if (done === 1'b1) done_cnt++;
            if (c < 26) cyc((c == 5 || c == 21), 1'b0, 7);
        end
        n_run++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_busy_jobs got=%0d busy=%b exp=1 busy=0", done_cnt, busy);
        end
    endtask

    task automatic test_mid_reset();
        int done_at = -1;
        cyc(1'b1, 1'b0, 3);
        for (int c = 1; c <= 34; c++) begin
            n_run++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mid_reset c%0d got=%h exp=%h", c, obs, exp_v);
            end
            if (c == 11) begin
                n_run++;
                if (obs !== 28'h0) begin
                    n_fail++;
                    $display("FAIL mid_reset_clear got=%h exp=0", obs);
                end
            end
            if (done === 1'b1 && done_at < 0) done_at = c;
            if (c < 34) cyc((c == 12), (c == 10), 3);
        end
        n_run++;
        if (done_at != 33) begin
            n_fail++;
            $display("FAIL mid_reset_done got=%0d exp=33", done_at);
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        cyc(1'b1, 1'b0, 2);
        for (int c = 1; c <= 42; c++) begin
            n_run++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back c%0d got=%h exp=%h", c, obs, exp_v);
            end
            if (done === 1'b1) dones++;
            // first job ends at 20; start again in the very first idle cycle
            if (c < 42) cyc((c == 21), 1'b0, 1);
        end
        n_run++;
        if (dones != 2) begin
            n_fail++;
            $display("FAIL back_to_back_jobs got=%0d exp=2", dones);
        end
    endtask

    task automatic test_max_len();
        cyc(1'b1, 1'b0, 255);
        for (int c = 1; c <= 276; c++) begin
            n_run++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL max_len c%0d got=%h exp=%h", c, obs, exp_v);
            end
            if (c < 276) cyc(1'b0, 1'b0, 0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0),
                int'($urandom_range(0, 12)));
            n_run++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random c%0d got=%h exp=%h", c, obs, exp_v);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_nominal();
        cyc(1'b0, 1'b0, 0);
        test_zero_len();
        cyc(1'b0, 1'b0, 0);
        test_start_while_busy();
        test_mid_reset();
        cyc(1'b0, 1'b0, 0);
        test_back_to_back();
        cyc(1'b0, 1'b0, 0);
        test_max_len();
        cyc(1'b0, 1'b0, 0);
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
